mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
//  Sequences one CPU memory transaction through the MAR/MDR datapath: loads MAR, loads MDR from bus (write) or memory (read), runs the memory handshake, and returns read data to the bus.
//  Sits between the control unit (req/done) and the MAR, MDR and memory strobes.
//  Adds a wait-state handshake with timeout so slow or absent memory cannot hang the CPU.
// PARAMETERS
//  TIMEOUT  16  max cycles spent in MEM waiting for mem_ready before aborting (>=2)
//  CNT_W    5   wait-counter width; must satisfy 2**CNT_W > TIMEOUT
// PORTS
//  clock       in   1  single system clock, all state updates on rising edge
//  clear       in   1  synchronous, active-high reset
//  req         in   1  start a transaction; sampled only in IDLE
//  req_write   in   1  1=write, 0=read; latched with req
//  mem_ready   in   1  memory completed access; sampled only in MEM
//  busy        out  1  high in every state except IDLE
//  done        out  1  one-cycle pulse, transaction finished
//  err         out  1  one-cycle pulse coincident with done on timeout
//  mar_in      out  1  load MAR from bus
//  mdr_enable  out  1  MDR register load enable
//  mdr_read    out  1  MDR source select: 1=memory lines, 0=bus
//  mdr_drive   out  1  MDR drives the bus
//  mem_read    out  1  memory read strobe
//  mem_write   out  1  memory write strobe
// BEHAVIOUR
//  - Moore FSM; all outputs decoded from the state register and the latched wr flag only. No output depends combinationally on an input.
//  - Reset (clear=1 at edge): state=IDLE, wr=0, counter=0. All outputs 0 from the next cycle, including mid-transaction: strobes drop and the access is abandoned with no done.
//  - IDLE: when req=1, latch wr<=req_write and go to ADDR. Otherwise stay in IDLE.
//  - ADDR, 1 cycle: mar_in=1. Next state is WLOAD if wr, else MEM. Counter cleared.
//  - WLOAD, 1 cycle, write only: mdr_enable=1, mdr_read=0. Next state MEM.
//  - MEM: mem_read=!wr, mem_write=wr, mdr_read=!wr. Counter increments each cycle.
//    - mem_ready=1: go to CAPTURE if read, DONE if write.
//    - else if counter==TIMEOUT-1: go to DONE with err_flag=1.
//    - mem_ready on the final cycle wins over timeout.
//  - CAPTURE, 1 cycle, read only: mdr_enable=1, mdr_read=1, mem_read held 1 so the data stays valid. Next state DONE.
//  - DONE, 1 cycle: done=1, err=err_flag, mdr_drive=(!wr && !err_flag). Next state IDLE; err_flag cleared.
//  - req is ignored while busy; no queuing. Back-to-back requests are therefore accepted at most once every 5 cycles (zero-wait read).
//  - Latency with mem_ready already high on the first MEM cycle: req at cycle N gives done at N+4 for both read and write. Each extra wait cycle adds 1.
//  - Timeout: exactly TIMEOUT MEM cycles, then DONE with err=1. MDR is not loaded and mdr_drive stays 0.
//  - mar_in, mdr_enable, mem_read and mem_write are never high in IDLE or DONE. mem_read and mem_write are never both high.
//  - Unused state encodings recover to IDLE.
// STRUCTURE
//  - Shared header mem_ctrl_defs.vh: state localparams (IDLE, ADDR, WLOAD, MEM, CAPTURE, DONE), 3-bit encoding, default TIMEOUT.
//  - One sub-module: wait_counter (sync clear, enable, count, terminal-compare output) used for the MEM timeout.
//  - Top level holds the FSM, the wr/err_flag registers and the output decode.
// TESTING
//  - Read, zero-wait: req=1, req_write=0, mem_ready=1 -> mar_in@N+1, mem_read@N+2, mdr_enable&mdr_read@N+3, done&mdr_drive@N+4, busy low at N+5.
//  - Write, 3 wait cycles: req_write=1, mem_ready rises on the 4th MEM cycle -> mar_in@N+1, mdr_enable&!mdr_read@N+2, mem_write N+3..N+6, done@N+7, mdr_drive=0.
//  - Timeout: TIMEOUT=16, mem_ready=0 -> mem_read high for exactly 16 cycles, then done=1 and err=1 for one cycle, mdr_enable never set in CAPTURE.
//  - Ready on the last cycle: mem_ready=1 on MEM cycle 16 -> normal completion, err=0.
//  - clear=1 while in MEM -> next cycle all outputs 0, busy=0, no done pulse; a following req completes normally.
//  - req held high continuously plus a req pulse while busy -> the second request is not latched; req_write toggling mid-transaction does not change strobes.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
// Shared state encoding and default sizing for the memory access controller.
// The state encoding is 3 bits wide. Encodings 6 and 7 are unused and recover to IDLE.
package mem_access_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR    = 3'd1,
    ST_WLOAD   = 3'd2,
    ST_MEM     = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  localparam int DEFAULT_TIMEOUT = 16;
  localparam int DEFAULT_CNT_W   = 5;

endpackage

// File: rtl/mem_access_ctrl_wait_counter.sv
// Wait-state counter for the MEM phase.
// It has a synchronous clear and a count enable, and flags the last permitted wait cycle.
module wait_counter
  import mem_access_ctrl_pkg::*;
#(
  parameter int CNT_W   = DEFAULT_CNT_W,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clock,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam logic [CNT_W-1:0] TERM_VAL = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clear)       cnt_d = '0;
    else if (enable) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    cnt_q <= cnt_d;
  end

  assign terminal = (cnt_q == TERM_VAL);

endmodule

// File: rtl/mem_access_ctrl.sv
// Moore FSM that sequences one MAR/MDR memory transaction.
// A wait-state timeout stops slow or absent memory from hanging the CPU.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int CNT_W   = DEFAULT_CNT_W
) (
  input  logic clock,
  input  logic clear,
  input  logic req,
  input  logic req_write,
  input  logic mem_ready,
  output logic busy,
  output logic done,
  output logic err,
  output logic mar_in,
  output logic mdr_enable,
  output logic mdr_read,
  output logic mdr_drive,
  output logic mem_read,
  output logic mem_write
);

  state_e state_d, state_q;
  logic   wr_d, wr_q;
  logic   err_flag_d, err_flag_q;
  logic   wait_last;

  // The counter only runs in MEM, so every other state holds it at zero.
  wait_counter #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) u_wait_counter (
    .clock    (clock),
    .clear    (clear || (state_q != ST_MEM)),
    .enable   (state_q == ST_MEM),
    .terminal (wait_last)
  );

  always_comb begin
    state_d    = state_q;
    wr_d       = wr_q;
    err_flag_d = err_flag_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          wr_d    = req_write;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR:    state_d = wr_q ? ST_WLOAD : ST_MEM;
      ST_WLOAD:   state_d = ST_MEM;
      ST_MEM: begin
        // If memory becomes ready on the final wait cycle, the access completes normally.
        if (mem_ready) begin
          state_d = wr_q ? ST_DONE : ST_CAPTURE;
        end else if (wait_last) begin
          state_d    = ST_DONE;
          err_flag_d = 1'b1;
        end
      end
      ST_CAPTURE: state_d = ST_DONE;
      ST_DONE: begin
        state_d    = ST_IDLE;
        err_flag_d = 1'b0;
      end
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q    <= ST_IDLE;
      wr_q       <= 1'b0;
      err_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_q       <= wr_d;
      err_flag_q <= err_flag_d;
    end
  end

  always_comb begin
    busy       = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    mar_in     = 1'b0;
    mdr_enable = 1'b0;
    mdr_read   = 1'b0;
    mdr_drive  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    case (state_q)
      ST_ADDR: begin
        busy   = 1'b1;
        mar_in = 1'b1;
      end
      ST_WLOAD: begin
        busy       = 1'b1;
        mdr_enable = 1'b1;
      end
      ST_MEM: begin
        busy      = 1'b1;
        mem_read  = !wr_q;
        mem_write = wr_q;
        mdr_read  = !wr_q;
      end
      // mem_read stays asserted while MDR samples, so the memory lines remain valid.
      ST_CAPTURE: begin
        busy       = 1'b1;
        mdr_enable = 1'b1;
        mdr_read   = 1'b1;
        mem_read   = 1'b1;
      end
      ST_DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        err       = err_flag_q;
        mdr_drive = !wr_q && !err_flag_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl. It checks outputs one cycle at a time against hand-written state patterns.
// Output vector order: {busy,done,err,mar_in,mdr_enable,mdr_read,mdr_drive,mem_read,mem_write}
module tb_mem_access_ctrl;

  logic clock = 1'b0;
  logic clear, req, req_write, mem_ready;
  logic busy, done, err, mar_in, mdr_enable, mdr_read, mdr_drive, mem_read, mem_write;

  int n_chk = 0;
  int n_bad = 0;

  localparam logic [8:0] O_IDLE  = 9'b0_0_0_0_0_0_0_0_0;
  localparam logic [8:0] O_ADDR  = 9'b1_0_0_1_0_0_0_0_0;
  localparam logic [8:0] O_WLOAD = 9'b1_0_0_0_1_0_0_0_0;
  localparam logic [8:0] O_MEM_R = 9'b1_0_0_0_0_1_0_1_0;
  localparam logic [8:0] O_MEM_W = 9'b1_0_0_0_0_0_0_0_1;
  localparam logic [8:0] O_CAP   = 9'b1_0_0_0_1_1_0_1_0;
  localparam logic [8:0] O_DONE_R= 9'b1_1_0_0_0_0_1_0_0;
  localparam logic [8:0] O_DONE_W= 9'b1_1_0_0_0_0_0_0_0;
  localparam logic [8:0] O_DONE_E= 9'b1_1_1_0_0_0_0_0_0;

  mem_access_ctrl #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clock      (clock),
    .clear      (clear),
    .req        (req),
    .req_write  (req_write),
    .mem_ready  (mem_ready),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .mar_in     (mar_in),
    .mdr_enable (mdr_enable),
    .mdr_read   (mdr_read),
    .mdr_drive  (mdr_drive),
    .mem_read   (mem_read),
    .mem_write  (mem_write)
  );

  always #5 clock = ~clock;

  function automatic logic [8:0] outs();
    return {busy, done, err, mar_in, mdr_enable, mdr_read, mdr_drive, mem_read, mem_write};
  endfunction

  task automatic chk(input string tag, input logic [8:0] got, input logic [8:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear = 1'b1; req = 1'b0; req_write = 1'b0; mem_ready = 1'b0;
    step(); step();
    chk("reset", outs(), O_IDLE);
    clear = 1'b0;
    step();
    chk("idle", outs(), O_IDLE);

    // zero-wait read
    mem_ready = 1'b1; req = 1'b1; req_write = 1'b0;
    step(); req = 1'b0;
    chk("rd_addr", outs(), O_ADDR);
    step(); chk("rd_mem", outs(), O_MEM_R);
    step(); chk("rd_cap", outs(), O_CAP);
    step(); chk("rd_done", outs(), O_DONE_R);
    step(); chk("rd_idle", outs(), O_IDLE);

    // write with three wait cycles, req_write toggled mid-transaction
    mem_ready = 1'b0; req = 1'b1; req_write = 1'b1;
    step(); req = 1'b0;
    chk("wr_addr", outs(), O_ADDR);
    step(); chk("wr_wload", outs(), O_WLOAD);
    req_write = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(); chk("wr_mem", outs(), O_MEM_W);
    end
    mem_ready = 1'b1;
    step(); chk("wr_done", outs(), O_DONE_W);
    mem_ready = 1'b0;
    step(); chk("wr_idle", outs(), O_IDLE);

    // timeout: exactly 16 MEM cycles, then an error done
    req = 1'b1; req_write = 1'b0;
    step(); req = 1'b0;
    chk("to_addr", outs(), O_ADDR);
    for (int i = 0; i < 16; i++) begin
      step(); chk("to_mem", outs(), O_MEM_R);
    end
    step(); chk("to_done", outs(), O_DONE_E);
    step(); chk("to_idle", outs(), O_IDLE);

    // ready arriving on the 16th MEM cycle beats the timeout
    req = 1'b1;
    step(); req = 1'b0;
    chk("lr_addr", outs(), O_ADDR);
    for (int i = 0; i < 16; i++) begin
      step(); chk("lr_mem", outs(), O_MEM_R);
    end
    mem_ready = 1'b1;
    step(); chk("lr_cap", outs(), O_CAP);
    mem_ready = 1'b0;
    step(); chk("lr_done", outs(), O_DONE_R);
    step(); chk("lr_idle", outs(), O_IDLE);

    // clear during MEM abandons the access with no done pulse
    req = 1'b1;
    step(); req = 1'b0;
    step(); step();
    chk("cl_mem", outs(), O_MEM_R);
    clear = 1'b1;
    step(); chk("cl_now", outs(), O_IDLE);
    clear = 1'b0;
    step(); chk("cl_after", outs(), O_IDLE);
    mem_ready = 1'b1; req = 1'b1;
    step(); req = 1'b0;
    chk("cl_addr", outs(), O_ADDR);
    step(); step();
    step(); chk("cl_done", outs(), O_DONE_R);
    step(); chk("cl_idle", outs(), O_IDLE);

    // req held high; req_write changes while busy
    req = 1'b1; req_write = 1'b0; mem_ready = 1'b1;
    step(); chk("hold_addr", outs(), O_ADDR);
    req_write = 1'b1;
    step(); chk("hold_mem", outs(), O_MEM_R);
    step(); chk("hold_cap", outs(), O_CAP);
    step(); chk("hold_done", outs(), O_DONE_R);
    step(); chk("hold_idle", outs(), O_IDLE);
    step(); chk("hold_addr2", outs(), O_ADDR);
    req = 1'b0;
    step(); chk("hold_wload", outs(), O_WLOAD);
    step(); chk("hold_memw", outs(), O_MEM_W);
    step(); chk("hold_donew", outs(), O_DONE_W);
    step(); chk("hold_end", outs(), O_IDLE);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
